// File: rtl/sys_cmd_pkg.sv
// Shared definitions for the host-side UART command master.
// Contents: protocol opcodes, command-type encodings, FSM state encoding.
package sys_cmd_pkg;

    localparam int unsigned OPCODE_W = 8;

    // First byte of each frame identifies the command to the system controller
    localparam logic [OPCODE_W-1:0] WRITE_CMD          = 8'hAA;
    localparam logic [OPCODE_W-1:0] READ_CMD           = 8'hBB;
    localparam logic [OPCODE_W-1:0] ALU_OPER_W_OP_CMD  = 8'hCC;
    localparam logic [OPCODE_W-1:0] ALU_OPER_W_NOP_CMD = 8'hDD;

    typedef enum logic [1:0] {
        CMD_WRITE   = 2'b00,
        CMD_READ    = 2'b01,
        CMD_ALU_OP  = 2'b10,
        CMD_ALU_NOP = 2'b11
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2
    } state_e;

endpackage

// File: rtl/sys_cmd_master.sv
// Host-side command initiator: serializes one command request into a UART
// byte frame, then gathers 0..2 response bytes into one response word.
// Ports: CLK/RST (async active-low), CMD_* request, CMD_BUSY, TX_DATA/TX_VLD/
// TX_BUSY toward the transmitter, RX_DATA/RX_VLD from the receiver,
// RSP_DATA/RSP_VLD/RSP_TIMEOUT completion.
// Optional: define CMD_TIMEOUT_EN to abort WAIT_RSP after TIMEOUT_CYCLES.
module sys_cmd_master
    import sys_cmd_pkg::*;
#(
    parameter int unsigned D_WIDTH        = 8,
    parameter int unsigned ADDRESS        = 4,
    parameter int unsigned FUNC_ALU       = 4,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 CMD_VLD,
    input  logic [1:0]           CMD_TYPE,
    input  logic [ADDRESS-1:0]   CMD_ADDR,
    input  logic [D_WIDTH-1:0]   CMD_DATA,
    input  logic [D_WIDTH-1:0]   CMD_OP_A,
    input  logic [D_WIDTH-1:0]   CMD_OP_B,
    input  logic [FUNC_ALU-1:0]  CMD_FUN,
    output logic                 CMD_BUSY,
    output logic [D_WIDTH-1:0]   TX_DATA,
    output logic                 TX_VLD,
    input  logic                 TX_BUSY,
    input  logic [D_WIDTH-1:0]   RX_DATA,
    input  logic                 RX_VLD,
    output logic [2*D_WIDTH-1:0] RSP_DATA,
    output logic                 RSP_VLD,
    output logic                 RSP_TIMEOUT
);

    localparam int unsigned RSP_W = 2 * D_WIDTH;

    state_e                    state_q, state_d;
    logic [3:0][D_WIDTH-1:0]   frame_q, frame_d;
    logic [1:0]                idx_q, idx_d;      // byte currently on TX_DATA
    logic [1:0]                last_q, last_d;    // index of final frame byte
    logic [1:0]                need_q, need_d;    // response bytes expected
    logic                      rx_cnt_q, rx_cnt_d;
    logic [D_WIDTH-1:0]        tx_data_q, tx_data_d;
    logic                      tx_vld_q, tx_vld_d;
    logic                      busy_q, busy_d;
    logic [RSP_W-1:0]          rsp_data_q, rsp_data_d;
    logic                      rsp_vld_q, rsp_vld_d;
    logic                      rx_final;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      tmo_q, tmo_d;
`else
    logic [31:0]               unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
`endif

    // Byte that completes the response (1st byte of a read, 2nd of an ALU op)
    assign rx_final = RX_VLD && ((need_q == 2'd1) || rx_cnt_q);

    // Next-state and next-output logic
    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        idx_d      = idx_q;
        last_d     = last_q;
        need_d     = need_q;
        rx_cnt_d   = rx_cnt_q;
        tx_data_d  = tx_data_q;
        tx_vld_d   = tx_vld_q;
        busy_d     = busy_q;
        rsp_data_d = rsp_data_q;
        rsp_vld_d  = 1'b0;
`ifdef CMD_TIMEOUT_EN
        cnt_d      = cnt_q;
        tmo_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                if (CMD_VLD) begin
                    frame_d = '0;
                    case (cmd_type_e'(CMD_TYPE))
                        CMD_WRITE: begin
                            frame_d[0] = D_WIDTH'(WRITE_CMD);
                            frame_d[1] = D_WIDTH'(CMD_ADDR);
                            frame_d[2] = CMD_DATA;
                            last_d     = 2'd2;
                            need_d     = 2'd0;
                        end
                        CMD_READ: begin
                            frame_d[0] = D_WIDTH'(READ_CMD);
                            frame_d[1] = D_WIDTH'(CMD_ADDR);
                            last_d     = 2'd1;
                            need_d     = 2'd1;
                        end
                        CMD_ALU_OP: begin
                            frame_d[0] = D_WIDTH'(ALU_OPER_W_OP_CMD);
                            frame_d[1] = CMD_OP_A;
                            frame_d[2] = CMD_OP_B;
                            frame_d[3] = D_WIDTH'(CMD_FUN);
                            last_d     = 2'd3;
                            need_d     = 2'd2;
                        end
                        CMD_ALU_NOP: begin
                            frame_d[0] = D_WIDTH'(ALU_OPER_W_NOP_CMD);
                            frame_d[1] = D_WIDTH'(CMD_FUN);
                            last_d     = 2'd1;
                            need_d     = 2'd2;
                        end
                    endcase
                    state_d    = ST_SEND;
                    idx_d      = 2'd0;
                    rx_cnt_d   = 1'b0;
                    tx_data_d  = frame_d[0];
                    tx_vld_d   = 1'b1;
                    busy_d     = 1'b1;
                    rsp_data_d = '0;
                end
            end
            ST_SEND: begin
                if (!TX_BUSY) begin
                    if (idx_q == last_q) begin
                        tx_vld_d = 1'b0;
                        if (need_q == 2'd0) begin
                            state_d   = ST_IDLE;
                            rsp_vld_d = 1'b1;
                            busy_d    = 1'b0;
                        end else begin
                            state_d = ST_WAIT_RSP;
`ifdef CMD_TIMEOUT_EN
                            cnt_d   = '0;
`endif
                        end
                    end else begin
                        idx_d     = idx_q + 2'd1;
                        tx_data_d = frame_q[idx_d];
                    end
                end
            end
            ST_WAIT_RSP: begin
                if (RX_VLD) begin
                    rx_cnt_d = 1'b1;
                    if (rx_cnt_q) rsp_data_d[RSP_W-1:D_WIDTH] = RX_DATA;
                    else          rsp_data_d[D_WIDTH-1:0]     = RX_DATA;
                end
                if (rx_final) begin
                    state_d   = ST_IDLE;
                    rsp_vld_d = 1'b1;
                    busy_d    = 1'b0;
                end
`ifdef CMD_TIMEOUT_EN
                // A final byte arriving on the expiry cycle takes priority
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d    = ST_IDLE;
                    tmo_d      = 1'b1;
                    busy_d     = 1'b0;
                    rsp_data_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`endif
            end
            default: begin
                state_d  = ST_IDLE;
                tx_vld_d = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_IDLE;
            frame_q    <= '0;
            idx_q      <= 2'd0;
            last_q     <= 2'd0;
            need_q     <= 2'd0;
            rx_cnt_q   <= 1'b0;
            tx_data_q  <= '0;
            tx_vld_q   <= 1'b0;
            busy_q     <= 1'b0;
            rsp_data_q <= '0;
            rsp_vld_q  <= 1'b0;
`ifdef CMD_TIMEOUT_EN
            cnt_q      <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            frame_q    <= frame_d;
            idx_q      <= idx_d;
            last_q     <= last_d;
            need_q     <= need_d;
            rx_cnt_q   <= rx_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_vld_q   <= tx_vld_d;
            busy_q     <= busy_d;
            rsp_data_q <= rsp_data_d;
            rsp_vld_q  <= rsp_vld_d;
`ifdef CMD_TIMEOUT_EN
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign CMD_BUSY = busy_q;
    assign TX_DATA  = tx_data_q;
    assign TX_VLD   = tx_vld_q;
    assign RSP_DATA = rsp_data_q;
    assign RSP_VLD  = rsp_vld_q;
`ifdef CMD_TIMEOUT_EN
    assign RSP_TIMEOUT = tmo_q;
`else
    assign RSP_TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_sys_cmd_master.sv
// Self-checking bench for sys_cmd_master: table vectors, corner sequences
// (reset abort, timeout / no-timeout) and randomized commands checked
// against a frame/response model derived from the protocol rules.
module tb_sys_cmd_master;

`ifdef CMD_TIMEOUT_EN
    localparam int unsigned TMO = 16;
`else
    localparam int unsigned TMO = 4096;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        CMD_VLD;
    logic [1:0]  CMD_TYPE;
    logic [3:0]  CMD_ADDR;
    logic [7:0]  CMD_DATA, CMD_OP_A, CMD_OP_B;
    logic [3:0]  CMD_FUN;
    logic        CMD_BUSY;
    logic [7:0]  TX_DATA;
    logic        TX_VLD;
    logic        TX_BUSY;
    logic [7:0]  RX_DATA;
    logic        RX_VLD;
    logic [15:0] RSP_DATA;
    logic        RSP_VLD;
    logic        RSP_TIMEOUT;

    int n_checks = 0;
    int n_pass   = 0;

    sys_cmd_master #(
        .D_WIDTH(8), .ADDRESS(4), .FUNC_ALU(4), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK(CLK), .RST(RST), .CMD_VLD(CMD_VLD), .CMD_TYPE(CMD_TYPE),
        .CMD_ADDR(CMD_ADDR), .CMD_DATA(CMD_DATA), .CMD_OP_A(CMD_OP_A),
        .CMD_OP_B(CMD_OP_B), .CMD_FUN(CMD_FUN), .CMD_BUSY(CMD_BUSY),
        .TX_DATA(TX_DATA), .TX_VLD(TX_VLD), .TX_BUSY(TX_BUSY),
        .RX_DATA(RX_DATA), .RX_VLD(RX_VLD), .RSP_DATA(RSP_DATA),
        .RSP_VLD(RSP_VLD), .RSP_TIMEOUT(RSP_TIMEOUT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]  typ;
        logic [3:0]  addr;
        logic [7:0]  data, a, b;
        logic [3:0]  fun;
        int          busy;     // TX_BUSY cycles before each byte transfers
        logic [7:0]  rx0, rx1;
        logic [15:0] exp_rsp;
    } vec_t;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Frame bytes (byte i at f[8*i+:8]), frame length, response byte count
    function automatic void frame_of(input vec_t v, output logic [31:0] f,
                                     output int n, output int nr);
        f = '0;
        case (v.typ)
            2'b00: begin f[7:0] = 8'hAA; f[15:8] = {4'h0, v.addr}; f[23:16] = v.data; n = 3; nr = 0; end
            2'b01: begin f[7:0] = 8'hBB; f[15:8] = {4'h0, v.addr}; n = 2; nr = 1; end
            2'b10: begin f[7:0] = 8'hCC; f[15:8] = v.a; f[23:16] = v.b; f[31:24] = {4'h0, v.fun}; n = 4; nr = 2; end
            default: begin f[7:0] = 8'hDD; f[15:8] = {4'h0, v.fun}; n = 2; nr = 2; end
        endcase
    endfunction

    function automatic logic [15:0] rsp_of(input vec_t v);
        case (v.typ)
            2'b00:   return 16'h0000;
            2'b01:   return {8'h00, v.rx0};
            default: return {v.rx1, v.rx0};
        endcase
    endfunction

    task automatic scramble_cmd();
        CMD_TYPE = 2'($urandom); CMD_ADDR = 4'($urandom); CMD_DATA = 8'($urandom);
        CMD_OP_A = 8'($urandom); CMD_OP_B = 8'($urandom); CMD_FUN = 4'($urandom);
    endtask

    task automatic noise_pulse(input bit noise);
        if (noise) begin
            scramble_cmd();
            CMD_VLD = 1'($urandom_range(0, 1));
            RX_VLD  = 1'($urandom_range(0, 1));
            RX_DATA = 8'($urandom);
        end
    endtask

    // Accept a command and transfer its frame; returns in the cycle after the last transfer
    task automatic send_cmd(input vec_t v, input bit noise);
        logic [31:0] f;
        int n, nr;
        frame_of(v, f, n, nr);
        check("idle_busy", 32'(CMD_BUSY), 0);
        CMD_TYPE = v.typ; CMD_ADDR = v.addr; CMD_DATA = v.data;
        CMD_OP_A = v.a; CMD_OP_B = v.b; CMD_FUN = v.fun; CMD_VLD = 1'b1;
        step();
        CMD_VLD = 1'b0;
        scramble_cmd();
        check("accept_busy", 32'(CMD_BUSY), 1);
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < v.busy; j++) begin
                TX_BUSY = 1'b1;
                noise_pulse(noise);
                check("tx_vld_hold", 32'(TX_VLD), 1);
                check("tx_data_hold", 32'(TX_DATA), 32'(f[8*i +: 8]));
                step();
                CMD_VLD = 1'b0; RX_VLD = 1'b0;
            end
            TX_BUSY = 1'b0;
            noise_pulse(noise);
            check("tx_vld", 32'(TX_VLD), 1);
            check("tx_byte", 32'(TX_DATA), 32'(f[8*i +: 8]));
            check("rsp_vld_send", 32'(RSP_VLD), 0);
            step();
            CMD_VLD = 1'b0; RX_VLD = 1'b0;
        end
        TX_BUSY = 1'($urandom_range(0, 1));
        check("tx_vld_drop", 32'(TX_VLD), 0);
    endtask

    // Deliver the response bytes with random gaps and check completion
    task automatic finish_rsp(input vec_t v, input bit noise);
        logic [31:0] f;
        int n, nr;
        frame_of(v, f, n, nr);
        if (nr > 0) begin
            check("wait_busy", 32'(CMD_BUSY), 1);
            check("wait_no_rsp", 32'(RSP_VLD), 0);
            for (int i = 0; i < nr; i++) begin
                repeat ($urandom_range(0, 3)) begin
                    if (noise) begin scramble_cmd(); CMD_VLD = 1'($urandom_range(0, 1)); end
                    step();
                    CMD_VLD = 1'b0;
                    check("gap_busy", 32'(CMD_BUSY), 1);
                end
                RX_DATA = (i == 0) ? v.rx0 : v.rx1;
                RX_VLD  = 1'b1;
                step();
                RX_VLD  = 1'b0;
                RX_DATA = 8'($urandom);
            end
        end
        check("rsp_vld", 32'(RSP_VLD), 1);
        check("rsp_data", 32'(RSP_DATA), 32'(v.exp_rsp));
        check("done_busy", 32'(CMD_BUSY), 0);
        check("no_timeout", 32'(RSP_TIMEOUT), 0);
        step();
        check("rsp_vld_pulse", 32'(RSP_VLD), 0);
        check("rsp_data_hold", 32'(RSP_DATA), 32'(v.exp_rsp));
    endtask

    vec_t tbl [5];
    vec_t v;
    logic [31:0] fr;
    int fn, fnr;

    initial begin
        tbl[0] = '{typ: 2'b00, addr: 4'h5, data: 8'h3C, a: 8'h00, b: 8'h00, fun: 4'h0,
                   busy: 0, rx0: 8'h00, rx1: 8'h00, exp_rsp: 16'h0000};
        tbl[1] = '{typ: 2'b01, addr: 4'h2, data: 8'h00, a: 8'h00, b: 8'h00, fun: 4'h0,
                   busy: 10, rx0: 8'h7E, rx1: 8'h00, exp_rsp: 16'h007E};
        tbl[2] = '{typ: 2'b10, addr: 4'h0, data: 8'h00, a: 8'h12, b: 8'h34, fun: 4'h2,
                   busy: 0, rx0: 8'hA8, rx1: 8'h03, exp_rsp: 16'h03A8};
        tbl[3] = '{typ: 2'b11, addr: 4'h0, data: 8'h00, a: 8'h00, b: 8'h00, fun: 4'h0,
                   busy: 2, rx0: 8'h55, rx1: 8'hAA, exp_rsp: 16'hAA55};
        tbl[4] = '{typ: 2'b00, addr: 4'hF, data: 8'hFF, a: 8'h00, b: 8'h00, fun: 4'hF,
                   busy: 3, rx0: 8'h00, rx1: 8'h00, exp_rsp: 16'h0000};

        RST = 1'b0; CMD_VLD = 1'b0; TX_BUSY = 1'b0; RX_VLD = 1'b0; RX_DATA = 8'h00;
        scramble_cmd();
        repeat (3) step();
        check("rst_busy", 32'(CMD_BUSY), 0);
        check("rst_tx_vld", 32'(TX_VLD), 0);
        check("rst_tx_data", 32'(TX_DATA), 0);
        check("rst_rsp_data", 32'(RSP_DATA), 0);
        check("rst_rsp_vld", 32'(RSP_VLD), 0);
        check("rst_timeout", 32'(RSP_TIMEOUT), 0);
        RST = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            send_cmd(tbl[i], i == 3);
            finish_rsp(tbl[i], i == 3);
        end

        // Reset asserted mid-frame after two ALU bytes have transferred
        v = '{typ: 2'b10, addr: 4'h0, data: 8'h00, a: 8'h9A, b: 8'h4C, fun: 4'h7,
              busy: 0, rx0: 8'h00, rx1: 8'h00, exp_rsp: 16'h0000};
        frame_of(v, fr, fn, fnr);
        CMD_TYPE = v.typ; CMD_OP_A = v.a; CMD_OP_B = v.b; CMD_FUN = v.fun; CMD_VLD = 1'b1;
        TX_BUSY = 1'b0;
        step();
        CMD_VLD = 1'b0;
        step();
        step();
        check("pre_rst_byte", 32'(TX_DATA), 32'(fr[23:16]));
        #2 RST = 1'b0;
        #1;
        check("abort_tx_vld", 32'(TX_VLD), 0);
        check("abort_tx_data", 32'(TX_DATA), 0);
        check("abort_busy", 32'(CMD_BUSY), 0);
        check("abort_rsp_vld", 32'(RSP_VLD), 0);
        check("abort_timeout", 32'(RSP_TIMEOUT), 0);
        step();
        RST = 1'b1;
        step();
        v = '{typ: 2'b00, addr: 4'hA, data: 8'h5B, a: 8'h00, b: 8'h00, fun: 4'h0,
              busy: 1, rx0: 8'h00, rx1: 8'h00, exp_rsp: 16'h0000};
        send_cmd(v, 1'b0);
        finish_rsp(v, 1'b0);

`ifdef CMD_TIMEOUT_EN
        // One of two ALU response bytes, then expiry: response discarded
        v = '{typ: 2'b11, addr: 4'h0, data: 8'h00, a: 8'h00, b: 8'h00, fun: 4'h3,
              busy: 0, rx0: 8'h00, rx1: 8'h00, exp_rsp: 16'h0000};
        send_cmd(v, 1'b0);
        for (int c = 1; c <= 16; c++) begin
            if (c == 3) begin RX_DATA = 8'h5A; RX_VLD = 1'b1; end
            step();
            RX_VLD = 1'b0;
            if (c < 16) begin
                check("tmo_early", 32'(RSP_TIMEOUT), 0);
                check("tmo_wait_busy", 32'(CMD_BUSY), 1);
            end else begin
                check("tmo_pulse", 32'(RSP_TIMEOUT), 1);
                check("tmo_rsp_data", 32'(RSP_DATA), 0);
                check("tmo_busy", 32'(CMD_BUSY), 0);
                check("tmo_no_vld", 32'(RSP_VLD), 0);
            end
        end
        step();
        check("tmo_one_pulse", 32'(RSP_TIMEOUT), 0);

        // Final byte on the expiry cycle: response wins
        v = '{typ: 2'b01, addr: 4'h9, data: 8'h00, a: 8'h00, b: 8'h00, fun: 4'h0,
              busy: 0, rx0: 8'hE1, rx1: 8'h00, exp_rsp: 16'h00E1};
        send_cmd(v, 1'b0);
        repeat (15) step();
        RX_DATA = v.rx0; RX_VLD = 1'b1;
        step();
        RX_VLD = 1'b0;
        check("win_rsp_vld", 32'(RSP_VLD), 1);
        check("win_no_tmo", 32'(RSP_TIMEOUT), 0);
        check("win_rsp_data", 32'(RSP_DATA), 32'(v.exp_rsp));
        step();
`else
        // No timeout: a read waits indefinitely for its response
        v = '{typ: 2'b01, addr: 4'h6, data: 8'h00, a: 8'h00, b: 8'h00, fun: 4'h0,
              busy: 0, rx0: 8'hC3, rx1: 8'h00, exp_rsp: 16'h00C3};
        send_cmd(v, 1'b0);
        for (int c = 0; c < 40; c++) begin
            step();
            check("notmo_quiet", 32'(RSP_TIMEOUT), 0);
        end
        finish_rsp(v, 1'b0);
`endif

        // Randomized commands against the model
        for (int i = 0; i < 40; i++) begin
            v.typ = 2'($urandom); v.addr = 4'($urandom); v.data = 8'($urandom);
            v.a = 8'($urandom); v.b = 8'($urandom); v.fun = 4'($urandom);
            v.busy = $urandom_range(0, 2);
            v.rx0 = 8'($urandom); v.rx1 = 8'($urandom);
            v.exp_rsp = rsp_of(v);
            send_cmd(v, 1'($urandom_range(0, 1)));
            finish_rsp(v, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
